// File: rtl/ham_reg_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ham_reg_bank_if                                            |
// | Description : Bus bundle for the SECDED-protected register bank.         |
// |               Carries the write port (with fault-injection mask), the    |
// |               combinational read port, scrubber control and the error    |
// |               statistics. clk_i / rst_i are not part of the bundle.      |
// |               master : configuration / PMU side (drives requests)        |
// |               slave  : register bank (drives read data and status)       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface ham_reg_bank_if #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) ();

  // Smallest Hamming parity count p with 2**p >= DATA_W + p + 1.
  function automatic int f_calc_p(input int dw);
    int r;
    r = 0;
    for (int p = 7; p >= 1; p--) begin
      if ((1 << p) >= dw + p + 1) r = p;
    end
    return r;
  endfunction

  localparam int c_AW     = $clog2(DEPTH);
  localparam int c_P      = f_calc_p(DATA_W);
  localparam int c_CODE_W = DATA_W + c_P + 1;

  // write port
  logic                we_i;
  logic [c_AW-1:0]     waddr_i;
  logic [DATA_W-1:0]   wdata_i;
  logic [c_CODE_W-1:0] inj_mask_i;
  // read port
  logic                re_i;
  logic [c_AW-1:0]     raddr_i;
  logic [DATA_W-1:0]   rdata_o;
  logic                rd_sec_o;
  logic                rd_ded_o;
  // scrubber control and statistics
  logic                scrub_en_i;
  logic                clr_i;
  logic [CNT_W-1:0]    sec_cnt_o;
  logic [CNT_W-1:0]    ded_cnt_o;
  logic                ded_sticky_o;
  logic                scrub_busy_o;

  modport master (
    output we_i, waddr_i, wdata_i, inj_mask_i,
    output re_i, raddr_i,
    output scrub_en_i, clr_i,
    input  rdata_o, rd_sec_o, rd_ded_o,
    input  sec_cnt_o, ded_cnt_o, ded_sticky_o, scrub_busy_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, inj_mask_i,
    input  re_i, raddr_i,
    input  scrub_en_i, clr_i,
    output rdata_o, rd_sec_o, rd_ded_o,
    output sec_cnt_o, ded_cnt_o, ded_sticky_o, scrub_busy_o
  );

endinterface
`default_nettype wire

// File: rtl/ham_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ham_reg_bank                                               |
// | Description : DEPTH-entry register bank, each entry held as an extended  |
// |               Hamming SECDED codeword. Corrects single errors on the     |
// |               combinational read port, runs a background scrubber that   |
// |               rewrites corrected words, keeps saturating SEC/DED counters|
// |               and supports write-path fault injection.                   |
// | Ports       : clk_i        clock                                         |
// |               rst_i        asynchronous reset, active high               |
// |               bus (slave)  we_i/waddr_i/wdata_i/inj_mask_i  write port   |
// |                            re_i/raddr_i -> rdata_o/rd_sec_o/rd_ded_o     |
// |                            scrub_en_i, clr_i                             |
// |                            sec_cnt_o, ded_cnt_o, ded_sticky_o,           |
// |                            scrub_busy_o                                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ham_reg_bank #(
  parameter int DATA_W         = 11,
  parameter int DEPTH          = 8,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ham_reg_bank_if.slave bus      // must be instantiated with matching DATA_W/DEPTH/CNT_W
);

  function automatic int f_calc_p(input int dw);
    int r;
    r = 0;
    for (int p = 7; p >= 1; p--) begin
      if ((1 << p) >= dw + p + 1) r = p;
    end
    return r;
  endfunction

  localparam int c_AW     = $clog2(DEPTH);
  localparam int c_P      = f_calc_p(DATA_W);
  localparam int c_CODE_W = DATA_W + c_P + 1;
  localparam int c_IW     = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [c_IW-1:0] c_INT_LAST = c_IW'(SCRUB_INTERVAL - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_READ = 2'd2;
  localparam logic [1:0] c_ST_WB   = 2'd3;

  // ---------------------------------------------------------------------------
  // Codec. Codeword bit 0 is overall parity, positions 2**k are Hamming parity,
  // remaining positions carry data bits in ascending order.
  // ---------------------------------------------------------------------------
  function automatic logic [c_CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [c_CODE_W-1:0] cw;
    logic                par;
    int                  k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < c_CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    // Parity slot 2**b is still zero while its own sum is formed, so
    // including it in the XOR is harmless.
    for (int b = 0; b < c_P; b++) begin
      par = 1'b0;
      for (int pos = 1; pos < c_CODE_W; pos++) begin
        if (((pos >> b) & 1) == 1) par = par ^ cw[pos];
      end
      cw[1 << b] = par;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [c_CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < c_CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  function automatic void f_decode(
    input  logic [c_CODE_W-1:0] cw,
    output logic [DATA_W-1:0]   data,
    output logic [c_CODE_W-1:0] fix,
    output logic                sec,
    output logic                ded
  );
    logic [c_P-1:0] syn;
    logic           q;
    syn = '0;
    for (int pos = 1; pos < c_CODE_W; pos++) begin
      if (cw[pos]) syn = syn ^ pos[c_P-1:0];
    end
    q   = ^cw;
    fix = cw;
    // Odd overall parity: single error at position syn (syn==0 -> bit 0).
    // A syndrome beyond the codeword is uncorrectable and left as is.
    if (q && (int'(syn) < c_CODE_W)) fix[syn] = ~cw[syn];
    sec  = q;
    ded  = ~q & (syn != '0);
    data = f_extract(fix);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and decoders
  // ---------------------------------------------------------------------------
  logic [c_CODE_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0]   w_rd_data;
  logic [c_CODE_W-1:0] w_rd_fix;
  logic                w_rd_sec;
  logic                w_rd_ded;

  logic [DATA_W-1:0]   w_sc_data;
  logic [c_CODE_W-1:0] w_sc_fix;
  logic                w_sc_sec;
  logic                w_sc_ded;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_AW-1:0]     r_idx;
  logic [c_IW-1:0]     r_int;
  logic [CNT_W-1:0]    r_sec_cnt;
  logic [CNT_W-1:0]    r_ded_cnt;
  logic                r_sticky;

  logic                w_int_done;
  logic                w_same_addr;
  logic                w_int_inc;
  logic                w_int_clr;
  logic                w_idx_inc;
  logic                w_wb_wr;
  logic                w_cnt_sec;
  logic                w_cnt_ded;
  logic                w_busy;

  always_comb begin
    w_rd_data = '0;
    w_rd_fix  = '0;
    w_rd_sec  = 1'b0;
    w_rd_ded  = 1'b0;
    f_decode(r_mem[bus.raddr_i], w_rd_data, w_rd_fix, w_rd_sec, w_rd_ded);
  end

  always_comb begin
    w_sc_data = '0;
    w_sc_fix  = '0;
    w_sc_sec  = 1'b0;
    w_sc_ded  = 1'b0;
    f_decode(r_mem[r_idx], w_sc_data, w_sc_fix, w_sc_sec, w_sc_ded);
  end

  // Functional write always wins the single write port; the scrubber only
  // writes back when no functional write is present.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.we_i) begin
      r_mem[bus.waddr_i] <= f_encode(bus.wdata_i) ^ bus.inj_mask_i;
    end else if (w_wb_wr) begin
      r_mem[r_idx] <= w_sc_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // Scrubber FSM
  // ---------------------------------------------------------------------------
  assign w_int_done  = (r_int == c_INT_LAST);
  assign w_same_addr = (bus.waddr_i == r_idx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.scrub_en_i) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: w_state_nxt = c_ST_WAIT;
        c_ST_WAIT: w_state_nxt = w_int_done ? c_ST_READ : c_ST_WAIT;
        c_ST_READ: w_state_nxt = w_sc_sec ? c_ST_WB : c_ST_WAIT;
        c_ST_WB:   w_state_nxt = (bus.we_i && !w_same_addr) ? c_ST_WB : c_ST_WAIT;
        default:   w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_int_inc = 1'b0;
    w_int_clr = 1'b0;
    w_idx_inc = 1'b0;
    w_wb_wr   = 1'b0;
    w_cnt_sec = 1'b0;
    w_cnt_ded = 1'b0;
    w_busy    = (r_state == c_ST_READ) || (r_state == c_ST_WB);
    if (bus.scrub_en_i) begin
      case (r_state)
        c_ST_WAIT: begin
          w_int_inc = ~w_int_done;
          w_int_clr = w_int_done;
        end
        c_ST_READ: begin
          w_cnt_sec = w_sc_sec;
          w_cnt_ded = w_sc_ded;
          w_idx_inc = ~w_sc_sec;
        end
        c_ST_WB: begin
          // A functional write to the entry being scrubbed supersedes the
          // writeback; a write elsewhere just delays it by a cycle.
          w_wb_wr   = ~bus.we_i;
          w_idx_inc = ~bus.we_i | w_same_addr;
        end
        default: ;
      endcase
    end
  end

  // idx wraps naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx <= '0;
      r_int <= '0;
    end else begin
      if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (w_int_clr)      r_int <= '0;
      else if (w_int_inc) r_int <= r_int + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics: clear dominates any same-cycle increment or sticky set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
      r_sticky  <= 1'b0;
    end else if (bus.clr_i) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
      r_sticky  <= 1'b0;
    end else begin
      if (w_cnt_sec && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + 1'b1;
      if (w_cnt_ded && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + 1'b1;
      if ((w_rd_ded && bus.re_i) || w_cnt_ded) r_sticky <= 1'b1;
    end
  end

  assign bus.rdata_o      = w_rd_data;
  assign bus.rd_sec_o     = w_rd_sec & bus.re_i;
  assign bus.rd_ded_o     = w_rd_ded & bus.re_i;
  assign bus.sec_cnt_o    = r_sec_cnt;
  assign bus.ded_cnt_o    = r_ded_cnt;
  assign bus.ded_sticky_o = r_sticky;
  assign bus.scrub_busy_o = w_busy;

endmodule
`default_nettype wire
